// File: rtl/need_update_arbiter.sv
// Pet need-level owner: serialises button increments and periodic decay through a
// single saturating read-modify-write path, decay first, buttons round-robin.
module need_update_arbiter #(
   parameter int TICK_DIV = 50_000_000,
   parameter int TEST_DIV = 8,
   parameter int LVL_W    = 3,
   parameter int MAX_LVL  = 5
) (
   input  logic             clk,
   input  logic             btn_reset,
   input  logic             btn_salud,
   input  logic             btn_energia,
   input  logic             btn_hambre,
   input  logic             btn_diversion,
   input  logic             btn_test,
   output logic [LVL_W-1:0] lvl_salud,
   output logic [LVL_W-1:0] lvl_energia,
   output logic [LVL_W-1:0] lvl_hambre,
   output logic [LVL_W-1:0] lvl_diversion,
   output logic             ledsign,
   output logic             test_mode,
   output logic             upd_valid,
   output logic [1:0]       upd_idx,
   output logic             upd_inc
);

   localparam int               MAX_DIV   = (TICK_DIV > TEST_DIV) ? TICK_DIV : TEST_DIV;
   localparam int               CNT_W     = $clog2(MAX_DIV);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] TEST_LAST = CNT_W'(TEST_DIV - 1);
   localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(MAX_LVL);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_APPLY = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [LVL_W-1:0] lvl_q [4];
   logic [LVL_W-1:0] lvl_d [4];
   logic [3:0]       pend_btn_q, pend_btn_d;
   logic [3:0]       btn_req, btn_clr;
   logic             pend_decay_q, pend_decay_d;
   logic             decay_clr, tick;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_last;
   logic             test_mode_q, test_mode_d;
   logic [1:0]       decay_ptr_q, decay_ptr_d;
   logic [1:0]       rr_ptr_q, rr_ptr_d;
   logic [1:0]       grant_idx_q, grant_idx_d;
   logic             grant_inc_q, grant_inc_d;
   logic             upd_valid_q, upd_valid_d;
   logic [1:0]       upd_idx_q, upd_idx_d;
   logic             upd_inc_q, upd_inc_d;
   logic             ledsign_q, ledsign_d;
   logic             btn_found;
   logic [1:0]       btn_idx;

   assign btn_req = {btn_diversion, btn_hambre, btn_energia, btn_salud};

   // First pending button at or above rr_ptr, wrapping modulo 4.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
      btn_found = 1'b0;
      btn_idx   = rr_ptr_q;
      for (int k = 0; k < 4; k++) begin
         if (!btn_found && pend_btn_q[rr_ptr_q + 2'(k)]) begin
            btn_found = 1'b1;
            btn_idx   = rr_ptr_q + 2'(k);
         end
      end
   end

   always_comb begin
      cnt_last    = test_mode_q ? TEST_LAST : TICK_LAST;
      test_mode_d = test_mode_q;
      tick        = 1'b0;
      cnt_d       = cnt_q + CNT_W'(1);
      if (btn_test) begin
         test_mode_d = ~test_mode_q;
         cnt_d       = '0;
      end else if (cnt_q == cnt_last) begin
         cnt_d = '0;
         tick  = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      grant_inc_d = grant_inc_q;
      btn_clr     = '0;
      decay_clr   = 1'b0;
      decay_ptr_d = decay_ptr_q;
      rr_ptr_d    = rr_ptr_q;
      lvl_d       = lvl_q;
      upd_valid_d = 1'b0;
      upd_idx_d   = upd_idx_q;
      upd_inc_d   = upd_inc_q;

      case (state_q)
         S_IDLE: begin
            if (pend_decay_q) begin
               grant_idx_d = decay_ptr_q;
               grant_inc_d = 1'b0;
               decay_clr   = 1'b1;
               state_d     = S_APPLY;
            end else if (btn_found) begin
               grant_idx_d      = btn_idx;
               grant_inc_d      = 1'b1;
               btn_clr[btn_idx] = 1'b1;
               state_d          = S_APPLY;
            end
         end
         S_APPLY: begin
            if (grant_inc_q) begin
               if (lvl_q[grant_idx_q] != LVL_MAX)
                  lvl_d[grant_idx_q] = lvl_q[grant_idx_q] + LVL_W'(1);
               rr_ptr_d = grant_idx_q + 2'd1;
            end else begin
               if (lvl_q[grant_idx_q] != '0)
                  lvl_d[grant_idx_q] = lvl_q[grant_idx_q] - LVL_W'(1);
               decay_ptr_d = decay_ptr_q + 2'd1;
            end
            upd_valid_d = 1'b1;
            upd_idx_d   = grant_idx_q;
            upd_inc_d   = grant_inc_q;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A new request wins over the clear from a grant in the same cycle.
      pend_btn_d   = (pend_btn_q & ~btn_clr) | btn_req;
      pend_decay_d = (pend_decay_q & ~decay_clr) | tick;

      ledsign_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (lvl_d[i] == '0) ledsign_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (btn_reset) begin
         state_q      <= S_IDLE;
         // NOTE: the level array is architectural state, so every entry is reset, not just the control.
         for (int i = 0; i < 4; i++) lvl_q[i] <= LVL_MAX;
         pend_btn_q   <= '0;
         pend_decay_q <= 1'b0;
         cnt_q        <= '0;
         test_mode_q  <= 1'b0;
         decay_ptr_q  <= '0;
         rr_ptr_q     <= '0;
         grant_idx_q  <= '0;
         grant_inc_q  <= 1'b0;
         upd_valid_q  <= 1'b0;
         upd_idx_q    <= '0;
         upd_inc_q    <= 1'b0;
         ledsign_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all registers see pre-edge values of each other.
         state_q      <= state_d;
         lvl_q        <= lvl_d;
         pend_btn_q   <= pend_btn_d;
         pend_decay_q <= pend_decay_d;
         cnt_q        <= cnt_d;
         test_mode_q  <= test_mode_d;
         decay_ptr_q  <= decay_ptr_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_idx_q  <= grant_idx_d;
         grant_inc_q  <= grant_inc_d;
         upd_valid_q  <= upd_valid_d;
         upd_idx_q    <= upd_idx_d;
         upd_inc_q    <= upd_inc_d;
         ledsign_q    <= ledsign_d;
      end
   end

   assign lvl_salud     = lvl_q[0];
   assign lvl_energia   = lvl_q[1];
   assign lvl_hambre    = lvl_q[2];
   assign lvl_diversion = lvl_q[3];
   assign ledsign       = ledsign_q;
   assign test_mode     = test_mode_q;
   assign upd_valid     = upd_valid_q;
   assign upd_idx       = upd_idx_q;
   assign upd_inc       = upd_inc_q;

endmodule

// File: tb/tb_need_update_arbiter.sv
// Directed bench for need_update_arbiter: expected updates (edge, index, direction, level)
// are queued as stimulus is scheduled and matched against every upd_valid pulse.
module tb_need_update_arbiter;

   logic       clk           = 1'b0;
   logic       btn_reset     = 1'b1;
   logic       btn_salud     = 1'b0;
   logic       btn_energia   = 1'b0;
   logic       btn_hambre    = 1'b0;
   logic       btn_diversion = 1'b0;
   logic       btn_test      = 1'b0;
   logic [2:0] lvl_salud, lvl_energia, lvl_hambre, lvl_diversion;
   logic       ledsign, test_mode, upd_valid, upd_inc;
   logic [1:0] upd_idx;

   always #5 clk = ~clk;

   need_update_arbiter #(
      .TICK_DIV (50_000_000),
      .TEST_DIV (8),
      .LVL_W    (3),
      .MAX_LVL  (5)
   ) dut (
      .clk           (clk),
      .btn_reset     (btn_reset),
      .btn_salud     (btn_salud),
      .btn_energia   (btn_energia),
      .btn_hambre    (btn_hambre),
      .btn_diversion (btn_diversion),
      .btn_test      (btn_test),
      .lvl_salud     (lvl_salud),
      .lvl_energia   (lvl_energia),
      .lvl_hambre    (lvl_hambre),
      .lvl_diversion (lvl_diversion),
      .ledsign       (ledsign),
      .test_mode     (test_mode),
      .upd_valid     (upd_valid),
      .upd_idx       (upd_idx),
      .upd_inc       (upd_inc)
   );

   typedef struct {
      int e;
      int idx;
      int inc;
      int lvl;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_t;
   int   lvl_m[4];
   int   edge_cnt = 0;
   int   checks   = 0;
   int   errors   = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] lvl_of(input int idx);
      case (idx)
         0:       return 32'(lvl_salud);
         1:       return 32'(lvl_energia);
         2:       return 32'(lvl_hambre);
         default: return 32'(lvl_diversion);
      endcase
   endfunction

   // Saturating reference levels; the queued level is the one expected right after the update.
   task automatic expect_upd(input int e, input int idx, input int inc);
      exp_t t;
      if (inc != 0) begin
         if (lvl_m[idx] < 5) lvl_m[idx]++;
      end else if (lvl_m[idx] > 0) begin
         lvl_m[idx]--;
      end
      t.e   = e;
      t.idx = idx;
      t.inc = inc;
      t.lvl = lvl_m[idx];
      exp_q.push_back(t);
   endtask

   task automatic wait_edge(input int e);
      while (edge_cnt < e) @(negedge clk);
   endtask

   // m = {test, diversion, hambre, energia, salud}, sampled at posedge e.
   task automatic pulse_at(input int e, input logic [4:0] m);
      wait_edge(e - 1);
      {btn_test, btn_diversion, btn_hambre, btn_energia, btn_salud} = m;
      wait_edge(e);
      {btn_test, btn_diversion, btn_hambre, btn_energia, btn_salud} = 5'b0;
   endtask

   always @(negedge clk) begin
      if (upd_valid === 1'b1) begin
         check("upd_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            mon_t = exp_q.pop_front();
            check("upd_edge", edge_cnt, mon_t.e);
            check("upd_idx", 32'(upd_idx), mon_t.idx);
            check("upd_inc", 32'(upd_inc), mon_t.inc);
            check("upd_level", lvl_of(mon_t.idx), mon_t.lvl);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      lvl_m = '{5, 5, 5, 5};

      // Reset state
      wait_edge(2);
      check("rst_salud", 32'(lvl_salud), 5);
      check("rst_energia", 32'(lvl_energia), 5);
      check("rst_hambre", 32'(lvl_hambre), 5);
      check("rst_diversion", 32'(lvl_diversion), 5);
      check("rst_ledsign", 32'(ledsign), 0);
      check("rst_test_mode", 32'(test_mode), 0);
      check("rst_upd_valid", 32'(upd_valid), 0);
      check("rst_upd_idx", 32'(upd_idx), 0);
      check("rst_upd_inc", 32'(upd_inc), 0);
      btn_reset = 1'b0;

      // Test mode decays in rotating order
      expect_upd(15, 0, 0);
      expect_upd(23, 1, 0);
      expect_upd(31, 2, 0);
      expect_upd(39, 3, 0);
      pulse_at(5, 5'b10000);
      check("test_mode_on", 32'(test_mode), 1);
      wait_edge(14);
      check("salud_before_tick", 32'(lvl_salud), 5);
      check("no_upd_before_tick", 32'(upd_valid), 0);
      wait_edge(15);
      check("salud_first_decay", 32'(lvl_salud), 4);
      wait_edge(39);
      check("diversion_decayed", 32'(lvl_diversion), 4);

      // Button latency and saturation
      expect_upd(43, 0, 1);
      expect_upd(45, 0, 1);
      expect_upd(47, 0, 0);
      pulse_at(41, 5'b00001);
      wait_edge(42);
      check("salud_not_yet", 32'(lvl_salud), 4);
      check("upd_not_yet", 32'(upd_valid), 0);
      pulse_at(43, 5'b00001);
      check("salud_incremented", 32'(lvl_salud), 5);
      check("upd_pulse_on", 32'(upd_valid), 1);
      wait_edge(44);
      check("upd_one_cycle", 32'(upd_valid), 0);
      wait_edge(45);
      check("salud_saturated", 32'(lvl_salud), 5);
      check("upd_on_saturation", 32'(upd_valid), 1);
      pulse_at(48, 5'b10000);
      check("test_mode_off", 32'(test_mode), 0);

      // Round-robin from rr_ptr=0, duplicate hambre dropped
      expect_upd(52, 3, 1);
      expect_upd(56, 0, 1);
      expect_upd(58, 1, 1);
      expect_upd(60, 2, 1);
      expect_upd(62, 3, 1);
      pulse_at(50, 5'b01000);
      pulse_at(54, 5'b01111);
      pulse_at(56, 5'b00100);
      wait_edge(64);
      check("rr_hambre_once", 32'(lvl_hambre), 5);
      check("rr_idle", 32'(upd_valid), 0);
      check("rr_drained", exp_q.size(), 0);

      // Decay beats a simultaneous button
      expect_upd(76, 1, 0);
      expect_upd(78, 1, 1);
      pulse_at(66, 5'b10000);
      pulse_at(74, 5'b00010);
      wait_edge(76);
      check("prio_decay_first", 32'(lvl_energia), 4);
      wait_edge(78);
      check("prio_button_after", 32'(lvl_energia), 5);

      // Long decay run to zero, saturation at 0, then one diversion press
      for (int k = 1; k <= 22; k++) expect_upd(76 + 8 * k, (k + 1) % 4, 0);
      expect_upd(256, 3, 1);
      expect_upd(260, 0, 0);
      wait_edge(211);
      check("ledsign_before_zero", 32'(ledsign), 0);
      wait_edge(212);
      check("hambre_zero", 32'(lvl_hambre), 0);
      check("ledsign_at_zero", 32'(ledsign), 1);
      wait_edge(236);
      check("all_zero_salud", 32'(lvl_salud), 0);
      check("all_zero_energia", 32'(lvl_energia), 0);
      check("all_zero_diversion", 32'(lvl_diversion), 0);
      check("all_zero_ledsign", 32'(ledsign), 1);
      wait_edge(252);
      check("zero_decay_pulses", 32'(upd_valid), 1);
      pulse_at(254, 5'b01000);
      wait_edge(256);
      check("diversion_from_zero", 32'(lvl_diversion), 1);
      check("ledsign_still_set", 32'(ledsign), 1);

      // Reset while an increment is in APPLY
      pulse_at(262, 5'b00001);
      wait_edge(263);
      btn_reset = 1'b1;
      wait_edge(264);
      btn_reset = 1'b0;
      check("apply_rst_salud", 32'(lvl_salud), 5);
      check("apply_rst_energia", 32'(lvl_energia), 5);
      check("apply_rst_hambre", 32'(lvl_hambre), 5);
      check("apply_rst_diversion", 32'(lvl_diversion), 5);
      check("apply_rst_upd_valid", 32'(upd_valid), 0);
      check("apply_rst_ledsign", 32'(ledsign), 0);
      check("apply_rst_test_mode", 32'(test_mode), 0);
      wait_edge(280);
      check("post_rst_quiet", 32'(upd_valid), 0);
      check("post_rst_salud", 32'(lvl_salud), 5);
      check("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/need_update_arbiter.md
Name: need_update_arbiter

Overview:
Owns the four pet need levels (salud, energia, hambre, diversion) and serialises every change to them through one saturating read-modify-write path. Two kinds of requester share the path: the four care buttons, which each request +1, and a periodic decay scheduler, which requests -1 on one need per tick in rotating order. It sits between the button debouncers and tamagotchi_fsm. It supplies the levels, the alarm LED and test-mode status that the FSM and display logic consume.

Parameters:
TICK_DIV, 50_000_000, clk cycles per decay tick in normal mode (>=2)
TEST_DIV, 8, clk cycles per decay tick in test mode (>=2)
LVL_W, 3, width of each need level
MAX_LVL, 5, maximum (and reset) level; must fit in LVL_W bits

Ports:
clk  in  1  system clock, all logic on rising edge
btn_reset  in  1  synchronous reset, active-high
btn_salud  in  1  debounced single-cycle pulse, request salud +1
btn_energia  in  1  debounced single-cycle pulse, request energia +1
btn_hambre  in  1  debounced single-cycle pulse, request hambre +1
btn_diversion  in  1  debounced single-cycle pulse, request diversion +1
btn_test  in  1  debounced single-cycle pulse, toggles test mode
lvl_salud  out  LVL_W  need level, index 0
lvl_energia  out  LVL_W  need level, index 1
lvl_hambre  out  LVL_W  need level, index 2
lvl_diversion  out  LVL_W  need level, index 3
ledsign  out  1  high while any level == 0
test_mode  out  1  high = decay runs at TEST_DIV
upd_valid  out  1  one-cycle pulse, a level update was applied this cycle
upd_idx  out  2  need index of the applied update (0..3 as above)
upd_inc  out  1  1 = increment request, 0 = decay request

Behaviour:
- Reset (btn_reset high at an edge): all levels = MAX_LVL, ledsign=0, test_mode=0, upd_valid=0, upd_idx=0, upd_inc=0. Pending flags, tick counter, decay_ptr and rr_ptr all go to 0. State goes to IDLE.
- Reset dominates every other input, including an update in APPLY; no partial update survives.
- Pending flags: pend_btn[3:0] and pend_decay.
  - A button pulse sets its pend bit. A pulse on a bit already set is dropped; there is no queue deeper than 1.
  - Set has priority over the clear caused by a grant in the same cycle.
- Tick counter:
  - Counts 0..DIV-1, where DIV = test_mode ? TEST_DIV : TICK_DIV.
  - On reaching DIV-1 it wraps to 0 and sets pend_decay.
  - A btn_test pulse toggles test_mode and clears the counter in the same edge. pend_decay is left unchanged.
- FSM with two states, IDLE and APPLY:
  - IDLE, pend_decay set: grant decay. idx = decay_ptr, inc = 0, clear pend_decay, go to APPLY.
  - IDLE, otherwise any pend_btn set: grant the first set bit searching upward from rr_ptr, mod 4. inc = 1, clear that bit, go to APPLY.
  - IDLE, nothing pending: stay in IDLE.
  - APPLY: write the level with saturation (inc at MAX_LVL stays MAX_LVL; dec at 0 stays 0). Assert upd_valid with upd_idx/upd_inc for exactly the following cycle. For a decay grant, decay_ptr = decay_ptr+1 mod 4; for a button grant, rr_ptr = idx+1 mod 4. Return to IDLE.
  - upd_valid pulses even when saturation leaves the value unchanged.
- Latency and throughput:
  - A pulse sampled at edge N sets pend at N, is granted at N+1, and the level updates at N+2.
  - upd_valid is high between edges N+2 and N+3.
  - Peak throughput is one update per 2 cycles.
- ledsign is registered. It is recomputed from the post-update levels at the same edge as the level write.
- Decay has strict priority over buttons. Buttons are round-robin among themselves, so no button starves for more than 3 button grants.

Test Plan:
1. Assert btn_reset 2 cycles -> all lvl_* = 5, ledsign=0, test_mode=0, upd_valid=0. Assert btn_reset while in APPLY -> levels return to 5 at next edge and upd_valid stays 0.
2. Pulse btn_test, then wait 8 cycles -> test_mode=1, upd_valid with upd_idx=0, upd_inc=0, lvl_salud=4. Next ticks decrement energia, hambre, diversion in that order.
3. After step 2, pulse btn_salud at edge N -> lvl_salud=5 at N+2, upd_valid high for exactly one cycle. Pulse again -> lvl_salud stays 5 and upd_valid still pulses.
4. Pulse all four buttons in the same cycle with rr_ptr=0 -> grants go to idx 0,1,2,3 at 2-cycle spacing. A second btn_hambre pulse while its bit is pending is dropped (only one hambre update).
5. Decay tick and btn_energia pulse in the same cycle -> decay update applied first, button update 2 cycles later.
6. In test mode run 20 ticks with no buttons -> all levels 0, ledsign=1. Further ticks keep levels 0 with upd_valid pulsing. One btn_diversion pulse -> lvl_diversion=1 and ledsign stays 1.
